// File: rtl/bttn_debounce.sv
// rtl/bttn_debounce.sv - push-button synchronizer, debounce FSM, press/release pulses and hold detect
module bttn_debounce #(
    parameter int DB_CYCLES   = 4,
    parameter int HOLD_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic bttn_raw,
    output logic bttn,
    output logic press,
    output logic release_pulse,
    output logic hold
);

    localparam int                CNT_W    = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [15:0]       HOLD_MAX = 16'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      hold_cnt_q, hold_cnt_d;
    logic             bttn_q, bttn_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             hold_q, hold_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            state_q    <= RELEASED;
            cnt_q      <= '0;
            hold_cnt_q <= '0;
            bttn_q     <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            hold_q     <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_cnt_q <= hold_cnt_d;
            bttn_q     <= bttn_d;
            press_q    <= press_d;
            release_q  <= release_d;
            hold_q     <= hold_d;
        end
    end

    always_comb begin
        sync1_d = bttn_raw;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;

        // A wait state only commits after DB_CYCLES+1 consecutive agreeing samples.
        case (state_q)
            RELEASED: begin
                if (sync2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync2_q) begin
                    state_d = RELEASED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!sync2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sync2_q) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = RELEASED;
        endcase

        bttn_d    = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
        press_d   = (state_q == PRESS_WAIT) && (state_d == PRESSED);
        release_d = (state_q == RELEASE_WAIT) && (state_d == RELEASED);

        // Counting on the next bttn value makes hold_cnt equal the number of bttn=1 cycles so far.
        if (!bttn_d) begin
            hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q;
        end else begin
            hold_cnt_d = hold_cnt_q + 16'd1;
        end
        hold_d = bttn_d && (hold_cnt_d == HOLD_MAX);
    end

    assign bttn          = bttn_q;
    assign press         = press_q;
    assign release_pulse = release_q;
    assign hold          = hold_q;

endmodule

// File: tb/tb_bttn_debounce.sv
// tb/tb_bttn_debounce.sv - event scoreboard bench for bttn_debounce (DB_CYCLES=4, HOLD_CYCLES=16)
module tb_bttn_debounce;

    localparam int EV_PRESS    = 1;
    localparam int EV_HOLD_ON  = 2;
    localparam int EV_RELEASE  = 3;
    localparam int EV_DROP     = 4;
    localparam int EV_HOLD_OFF = 5;

    typedef struct {
        int kind;
        int at;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bttn_raw = 1'b1;
    logic bttn, press, release_pulse, hold;

    int   edge_n = 0;
    int   total = 0;
    int   bad = 0;
    ev_t  sb_q[$];
    logic bttn_prev = 1'b0;
    logic hold_prev = 1'b0;

    bttn_debounce #(.DB_CYCLES(4), .HOLD_CYCLES(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .bttn_raw     (bttn_raw),
        .bttn         (bttn),
        .press        (press),
        .release_pulse(release_pulse),
        .hold         (hold)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, exp);
        end
    endtask

    task automatic push(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input int kind);
        ev_t e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected at edge %0d: got event %0d expected none", edge_n, kind);
        end else begin
            e = sb_q.pop_front();
            check("sb_kind", kind, e.kind);
            check("sb_edge", edge_n, e.at);
        end
    endtask

    // Monitor: decodes output transitions into events and retires them against the scoreboard.
    always @(negedge clk) begin
        check("no_overlap", {31'd0, press & release_pulse}, 0);
        check("press_edge", {31'd0, press}, {31'd0, bttn & ~bttn_prev});
        check("hold_implies_bttn", {31'd0, hold & ~bttn}, 0);
        if (press)                                  sb_pop(EV_PRESS);
        if (hold && !hold_prev)                     sb_pop(EV_HOLD_ON);
        if (release_pulse)                          sb_pop(EV_RELEASE);
        if (bttn_prev && !bttn && !release_pulse)   sb_pop(EV_DROP);
        if (hold_prev && !hold)                     sb_pop(EV_HOLD_OFF);
        bttn_prev = bttn;
        hold_prev = hold;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raw goes high at negedge k, so it is first sampled at edge k+1 and bttn rises after edge k+7.
    task automatic pulse_raw(input int len, input bit exp_press, input bit exp_hold);
        int k;
        k = edge_n;
        if (exp_press) push(EV_PRESS, k + 7);
        if (exp_hold)  push(EV_HOLD_ON, k + 22);
        bttn_raw = 1'b1;
        idle(len);
        bttn_raw = 1'b0;
        if (exp_press) push(EV_RELEASE, k + len + 7);
        if (exp_hold)  push(EV_HOLD_OFF, k + len + 7);
        idle(12);
    endtask

    task automatic bounce();
        bttn_raw = 1'b1; idle(1);
        bttn_raw = 1'b0; idle(1);
        bttn_raw = 1'b1; idle(1);
        bttn_raw = 1'b0; idle(12);
    endtask

    task automatic release_glitch();
        int k;
        k = edge_n;
        push(EV_PRESS, k + 7);
        push(EV_HOLD_ON, k + 22);
        bttn_raw = 1'b1;
        idle(10);
        bttn_raw = 1'b0;
        idle(3);
        bttn_raw = 1'b1;
        idle(17);
        bttn_raw = 1'b0;
        push(EV_RELEASE, k + 37);
        push(EV_HOLD_OFF, k + 37);
        idle(12);
    endtask

    task automatic reset_while_pressed();
        int k;
        k = edge_n;
        push(EV_PRESS, k + 7);
        push(EV_HOLD_ON, k + 22);
        bttn_raw = 1'b1;
        idle(25);
        rst = 1'b1;
        push(EV_DROP, k + 26);
        push(EV_HOLD_OFF, k + 26);
        idle(1);
        check("rst_mid_bttn", {31'd0, bttn}, 0);
        check("rst_mid_hold", {31'd0, hold}, 0);
        check("rst_mid_release", {31'd0, release_pulse}, 0);
        idle(1);
        rst = 1'b0;
        push(EV_PRESS, k + 34);
        idle(10);
        bttn_raw = 1'b0;
        push(EV_RELEASE, k + 44);
        idle(12);
    endtask

    initial begin
        @(negedge clk);
        check("rst_e1_outputs", {28'd0, bttn, press, release_pulse, hold}, 0);
        @(negedge clk);
        check("rst_e2_outputs", {28'd0, bttn, press, release_pulse, hold}, 0);
        rst = 1'b0;
        push(EV_PRESS, edge_n + 7);
        @(negedge clk);
        check("post_rst_outputs", {28'd0, bttn, press, release_pulse, hold}, 0);
        idle(8);
        bttn_raw = 1'b0;
        push(EV_RELEASE, edge_n + 7);
        idle(12);

        pulse_raw(4, 1'b0, 1'b0);
        pulse_raw(5, 1'b1, 1'b0);
        pulse_raw(15, 1'b1, 1'b0);
        pulse_raw(16, 1'b1, 1'b1);
        pulse_raw(30, 1'b1, 1'b1);
        bounce();
        release_glitch();
        reset_while_pressed();

        check("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bttn_debounce.md
BTTN_DEBOUNCE -- requirements
Module: bttn_debounce

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 4, meaning the number of consecutive stable synchronized cycles required in a wait state (legal range 2..255).
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 16, meaning the number of cycles of debounced press after which hold asserts (legal range 1..65535).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port bttn_raw  input  1  asynchronous, bouncing push-button level.
REQ-006 The block SHALL have port bttn  output  1  debounced button level, which drives the downstream light controller's bttn input.
REQ-007 The block SHALL have port press  output  1  one-cycle pulse on a debounced 0->1 transition.
REQ-008 The block SHALL have port release  output  1  one-cycle pulse on a debounced 1->0 transition.
REQ-009 The block SHALL have port hold  output  1  level output, high while the debounced press has lasted at least HOLD_CYCLES cycles.

Function
REQ-010 The block SHALL pass bttn_raw through two flip-flops (sync1, sync2); only sync2 (called sync) SHALL feed the logic.
REQ-011 The FSM SHALL have four states: RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-012 In RELEASED, sync=1 SHALL move the FSM to PRESS_WAIT with cnt<=0; otherwise it SHALL stay in RELEASED.
REQ-013 In PRESS_WAIT, sync=0 SHALL return the FSM to RELEASED (bounce rejected, no pulse), sync=1 with cnt==DB_CYCLES-1 SHALL move it to PRESSED, and sync=1 otherwise SHALL increment cnt.
REQ-014 In PRESSED, sync=0 SHALL move the FSM to RELEASE_WAIT with cnt<=0; otherwise it SHALL stay in PRESSED.
REQ-015 In RELEASE_WAIT, sync=1 SHALL return the FSM to PRESSED (no pulse), sync=0 with cnt==DB_CYCLES-1 SHALL move it to RELEASED, and sync=0 otherwise SHALL increment cnt.
REQ-016 bttn SHALL be registered and equal 1 exactly while the state is PRESSED or RELEASE_WAIT.
REQ-017 press SHALL be high for exactly the one cycle following the PRESS_WAIT->PRESSED edge, coincident with the first cycle of bttn=1.
REQ-018 release SHALL be high for exactly the one cycle following the RELEASE_WAIT->RELEASED edge, coincident with the first cycle of bttn=0.
REQ-019 press and release SHALL never be high in the same cycle.
REQ-020 Latency: if bttn_raw is first sampled high at edge N and held stable, bttn SHALL rise after edge N+DB_CYCLES+2; release latency SHALL be symmetric.
REQ-021 Any bounce shorter than DB_CYCLES+1 synchronized cycles SHALL leave bttn, press and release unchanged.
REQ-022 hold_cnt SHALL clear to 0 whenever bttn=0.
REQ-023 hold_cnt SHALL increment each cycle bttn=1, saturating at HOLD_CYCLES with no wrap-around.
REQ-024 hold SHALL be 1 exactly while hold_cnt==HOLD_CYCLES and bttn=1.
REQ-025 A return from RELEASE_WAIT to PRESSED SHALL NOT clear hold_cnt or hold.
REQ-026 cnt SHALL be wide enough for DB_CYCLES-1 and SHALL NOT wrap.

Reset
REQ-027 With rst=1 at a clock edge, the block SHALL set sync1=0, sync2=0, state=RELEASED, cnt=0 and hold_cnt=0.
REQ-028 With rst=1 at a clock edge, the block SHALL set bttn=0, press=0, release=0 and hold=0.
REQ-029 rst SHALL take priority over all other transitions.
REQ-030 Reset asserted mid-press SHALL drop bttn to 0 with no release pulse.
REQ-031 After rst deasserts with bttn_raw=1 held, the block SHALL perform a full debounce (REQ-020) before bttn rises.

Verification (DB_CYCLES=4, HOLD_CYCLES=16)
REQ-032 Reset: rst=1 for 2 cycles with bttn_raw=1 -> all outputs 0 during reset and on the first cycle after.
REQ-033 Clean press: bttn_raw 0->1 sampled at edge N -> bttn=1 and press=1 after edge N+6, and press=0 after edge N+7.
REQ-034 Bounce: bttn_raw toggles 1,0,1,0 each cycle then returns to 0 -> bttn, press and release stay 0 throughout.
REQ-035 Release glitch: while pressed, bttn_raw=0 for 3 cycles then 1 -> bttn stays 1, no release pulse, hold_cnt keeps counting.
REQ-036 Long press and release: bttn_raw=1 held 30 cycles -> hold=1 from the 16th cycle of bttn=1; then bttn_raw=0 -> release pulse one cycle, and bttn=0, hold=0 in the same cycle.
REQ-037 Reset while pressed: assert rst while bttn=1 -> bttn=0 and hold=0 after that edge, release never pulses.
